compmag_seq: RTL and testbench

COMPMAG_SEQ -- requirements
Module: compmag_seq

---
 rtl/compmag_seq_if.sv | 33 +++
 rtl/compmag_seq.sv | 129 ++++++++++++
 tb/tb_compmag_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/compmag_seq_if.sv
// compmag_seq_if
// Bundles the start/operand request and the busy/done/result response of the
// sequential magnitude comparator.
//   start      : request to begin a comparison
//   a, b       : operands (WIDTH bits), sampled on an accepted start
//   sgn        : 1 = two's-complement compare, 0 = unsigned
//   busy       : comparison in progress
//   done       : one-cycle pulse when aeqb/agtb/altb carry a new result
//   aeqb/agtb/altb : result flags, held until the next done
// The WIDTH given here must match the WIDTH of the compmag_seq it connects to.
interface compmag_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sgn;
  logic             busy;
  logic             done;
  logic             aeqb;
  logic             agtb;
  logic             altb;

  modport master (
    output start, a, b, sgn,
    input  busy, done, aeqb, agtb, altb
  );

  modport slave (
    input  start, a, b, sgn,
    output busy, done, aeqb, agtb, altb
  );
endinterface

// File: rtl/compmag_seq.sv
// compmag_seq
// Sequential magnitude comparator: compares two WIDTH-bit operands SLICE bits
// per cycle, most-significant slice first, stopping at the first slice that
// differs. Latency from the accepting edge to done is the number of slices
// examined (1..WIDTH/SLICE). A start seen during the done cycle is accepted.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : compmag_seq_if.slave (start/a/b/sgn in, busy/done/aeqb/agtb/altb out)
module compmag_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  compmag_seq_if.slave bus
);

  if (SLICE < 1) begin : g_bad_slice
    $error("compmag_seq: SLICE must be >= 1");
  end else if ((WIDTH % SLICE) != 0) begin : g_bad_width
    $error("compmag_seq: WIDTH must be a multiple of SLICE");
  end

  localparam int NSL = (SLICE >= 1) ? (WIDTH / SLICE) : 1;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [SLICE-1:0] sa, sb, smask;

  // Current slice of each operand. For a signed compare of the MSB slice,
  // inverting the sign bit of both slices turns the signed ordering into an
  // unsigned one, so a single unsigned comparator covers both cases.
  always_comb begin
    a_sh  = a_q >> (int'(idx_q) * SLICE);
    b_sh  = b_q >> (int'(idx_q) * SLICE);
    smask = '0;
    smask[SLICE-1] = sgn_q && (idx_q == IW'(NSL - 1));
    sa    = a_sh[SLICE-1:0] ^ smask;
    sb    = b_sh[SLICE-1:0] ^ smask;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sgn_d   = bus.sgn;
          idx_d   = IW'(NSL - 1);
          state_d = CMP;
        end
      end
      CMP: begin
        if (sa != sb) begin
          eq_d    = 1'b0;
          gt_d    = (sa > sb);
          lt_d    = (sa < sb);
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CMP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.aeqb = eq_q;
  assign bus.agtb = gt_q;
  assign bus.altb = lt_q;

endmodule

// File: tb/tb_compmag_seq.sv
module tb_compmag_seq;
  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int NSL   = WIDTH / SLICE;

  typedef struct {
    int done_edge;
    bit eq;
    bit gt;
    bit lt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   edge_n;
  int   checks;
  int   failures;
  int   acc_edge;
  int   free_edge;
  exp_t sb_q[$];
  bit   last_eq, last_gt, last_lt;

  compmag_seq_if #(.WIDTH(WIDTH)) bus ();

  compmag_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_n);
    end
  endtask

  // Reference: result from full-word arithmetic; latency is the count of
  // slices scanned from the top down to the first one that differs.
  function automatic void ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input bit s, output int k, output bit eq,
                                  output bit gt, output bit lt);
    longint av, bv;
    logic [WIDTH-1:0] sa, sb;
    bit found;
    k = NSL;
    found = 1'b0;
    for (int i = NSL - 1; i >= 0; i--) begin
      sa = a >> (i * SLICE);
      sb = b >> (i * SLICE);
      if (!found && (sa[SLICE-1:0] != sb[SLICE-1:0])) begin
        k = NSL - i;
        found = 1'b1;
      end
    end
    if (s) begin
      av = longint'($signed(a));
      bv = longint'($signed(b));
    end else begin
      av = longint'(a);
      bv = longint'(b);
    end
    eq = (av == bv);
    gt = (av > bv);
    lt = (av < bv);
  endfunction

  // One cycle of stimulus: drive inputs for the next edge and, if the model
  // says the DUT is idle at that edge, push the expected result.
  task automatic step(input bit s, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input bit sg);
    int e, k;
    bit eq, gt, lt;
    exp_t it;
    @(posedge clk);
    #2;
    chk("busy", int'(bus.busy), int'(edge_n >= acc_edge && edge_n < free_edge - 1));
    bus.start = s;
    bus.a     = av;
    bus.b     = bv;
    bus.sgn   = sg;
    e = edge_n + 1;
    if (s && e >= free_edge) begin
      ref_cmp(av, bv, sg, k, eq, gt, lt);
      it.done_edge = e + k;
      it.eq = eq;
      it.gt = gt;
      it.lt = lt;
      sb_q.push_back(it);
      acc_edge  = e;
      free_edge = e + k + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic one(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input bit sg);
    step(1'b1, av, bv, sg);
    idle(NSL + 2);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    sb_q.delete();
    acc_edge  = -1;
    free_edge = 0;
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_aeqb", int'(bus.aeqb), 0);
    chk("rst_agtb", int'(bus.agtb), 0);
    chk("rst_altb", int'(bus.altb), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: pops an expectation on every done and checks that the flags
  // otherwise hold the last reported result.
  always @(negedge clk) begin
    exp_t it;
    if (!rst_n) begin
      last_eq = 1'b0;
      last_gt = 1'b0;
      last_lt = 1'b0;
    end else begin
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          it = sb_q.pop_front();
          chk("done_edge", edge_n, it.done_edge);
          last_eq = it.eq;
          last_gt = it.gt;
          last_lt = it.lt;
        end
      end
      chk("aeqb", int'(bus.aeqb), int'(last_eq));
      chk("agtb", int'(bus.agtb), int'(last_gt));
      chk("altb", int'(bus.altb), int'(last_lt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] av, bv;
    int sl;
    checks    = 0;
    failures  = 0;
    acc_edge  = -1;
    free_edge = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.sgn   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("por_busy", int'(bus.busy), 0);
    chk("por_done", int'(bus.done), 0);
    chk("por_aeqb", int'(bus.aeqb), 0);
    chk("por_agtb", int'(bus.agtb), 0);
    chk("por_altb", int'(bus.altb), 0);
    rst_n = 1'b1;
    idle(2);

    one(16'h1234, 16'h1234, 1'b0);
    one(16'h8000, 16'h7FFF, 1'b0);
    one(16'h8000, 16'h7FFF, 1'b1);
    one(16'h1235, 16'h1234, 1'b0);
    one(16'hFFFE, 16'hFFFF, 1'b1);

    // second start one cycle later must be ignored
    step(1'b1, 16'h1200, 16'h1234, 1'b0);
    step(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    idle(NSL + 2);

    // reset two cycles into an equal compare, then a normal compare
    step(1'b1, 16'h5A5A, 16'h5A5A, 1'b0);
    idle(2);
    do_reset();
    one(16'h5A5A, 16'h5A5A, 1'b0);
    one(16'h0001, 16'hFFFF, 1'b1);

    // start held high across done with alternating operands
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) step(1'b1, 16'h1234, 16'h1230, 1'b0);
      else            step(1'b1, 16'h8000, 16'h0001, 1'b1);
    end
    idle(NSL + 2);

    // randomized traffic; b shares most slices with a to spread latencies
    for (int i = 0; i < 300; i++) begin
      av = WIDTH'($urandom);
      bv = av;
      sl = int'($urandom_range(0, NSL + 1));
      if (sl < NSL)
        bv = av ^ (WIDTH'($urandom_range(1, (1 << SLICE) - 1)) << (sl * SLICE));
      else if (sl == NSL + 1)
        bv = WIDTH'($urandom);
      step(($urandom_range(0, 2) != 0), av, bv, 1'($urandom_range(0, 1)));
    end
    idle(NSL + 4);

    chk("pending_results", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
